// File: rtl/regfile_write_merge_pkg.sv
// Shared types for the RegFile write-merge front end.
//  - Default address/data widths of the RegFile write port.
//  - grant_e: which holding slot the arbiter drains on a given edge.
//  - oldest_grant(): picks the slot to drain from the slot valids and age flag.
package regfile_write_merge_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 5;
  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_SLOT0 = 2'd1,
    GNT_SLOT1 = 2'd2
  } grant_e;

  // A lone valid slot is always the oldest; the age flag only breaks the tie
  // when both slots hold a write.
  function automatic grant_e oldest_grant(input logic v0, input logic v1,
                                          input logic slot1_older);
    if (v0 && v1) return slot1_older ? GNT_SLOT1 : GNT_SLOT0;
    else if (v0)  return GNT_SLOT0;
    else if (v1)  return GNT_SLOT1;
    else          return GNT_NONE;
  endfunction

endpackage

// File: rtl/regfile_wr_slot.sv
// One holding entry for a write requester.
// Ports:
//  clk, rst_n            clock, asynchronous active-low reset
//  load                  capture load_addr/load_data and mark the entry valid
//  clear                 drop the entry (it has been granted)
//  load_addr, load_data  write to capture
//  valid, addr, data     current entry contents
// load and clear never coincide in practice (load needs an empty entry, clear a
// full one); load wins if they ever do.
module regfile_wr_slot #(
  parameter int addr_width = 5,
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  clear,
  input  logic [addr_width-1:0] load_addr,
  input  logic [data_width-1:0] load_data,
  output logic                  valid,
  output logic [addr_width-1:0] addr,
  output logic [data_width-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_merge.sv
// Write-side front end of the multi-ported RegFile.
// Merges two write requesters into the single RegFile write port in arrival
// order, and offers a combinational pending-write check with forwarding.
// Ports:
//  CLK, RST_N                         clock, asynchronous active-low reset
//  EN_REQn, REQn_ADDR, REQn_DATA      enqueue a write on channel n (n = 0, 1)
//  RDY_REQn                           channel n holding slot is free
//  WE, ADDR_IN, D_IN                  registered RegFile write port
//  CHK_ADDR                           address to check for pending writes
//  CHK_PENDING, CHK_DATA              uncommitted write exists / youngest data
// Handshake: a channel enqueues on a posedge where EN_REQn and RDY_REQn are both
// high; EN_REQn while RDY_REQn is low is ignored. RDY_REQn depends only on the
// registered slot valid, so a slot drained on edge k accepts again on edge k+1.
module regfile_write_merge
  import regfile_write_merge_pkg::*;
#(
  parameter int addr_width = ADDR_WIDTH_DEFAULT,
  parameter int data_width = DATA_WIDTH_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN_REQ0,
  input  logic [addr_width-1:0] REQ0_ADDR,
  input  logic [data_width-1:0] REQ0_DATA,
  output logic                  RDY_REQ0,
  input  logic                  EN_REQ1,
  input  logic [addr_width-1:0] REQ1_ADDR,
  input  logic [data_width-1:0] REQ1_DATA,
  output logic                  RDY_REQ1,
  output logic                  WE,
  output logic [addr_width-1:0] ADDR_IN,
  output logic [data_width-1:0] D_IN,
  input  logic [addr_width-1:0] CHK_ADDR,
  output logic                  CHK_PENDING,
  output logic [data_width-1:0] CHK_DATA
);

  logic                  v0, v1;
  logic [addr_width-1:0] a0, a1;
  logic [data_width-1:0] d0, d1;
  logic                  enq0, enq1;
  logic                  gnt0, gnt1;
  grant_e                gnt;
  logic                  age;       // 1: slot1 holds the older write
  logic                  age_next;
  logic                  v0_next, v1_next;

  assign RDY_REQ0 = RST_N & ~v0;
  assign RDY_REQ1 = RST_N & ~v1;
  assign enq0     = EN_REQ0 & RDY_REQ0;
  assign enq1     = EN_REQ1 & RDY_REQ1;

  assign gnt  = oldest_grant(v0, v1, age);
  assign gnt0 = (gnt == GNT_SLOT0);
  assign gnt1 = (gnt == GNT_SLOT1);

  regfile_wr_slot #(.addr_width(addr_width), .data_width(data_width)) u_slot0 (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (enq0),
    .clear     (gnt0),
    .load_addr (REQ0_ADDR),
    .load_data (REQ0_DATA),
    .valid     (v0),
    .addr      (a0),
    .data      (d0)
  );

  regfile_wr_slot #(.addr_width(addr_width), .data_width(data_width)) u_slot1 (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (enq1),
    .clear     (gnt1),
    .load_addr (REQ1_ADDR),
    .load_data (REQ1_DATA),
    .valid     (v1),
    .addr      (a1),
    .data      (d1)
  );

  // Age is derived from which slots are occupied after this edge. When both
  // are occupied, the slot that survived from before the edge is older; on a
  // double enqueue into two empty slots, REQ0 counts as older.
  assign v0_next = enq0 | (v0 & ~gnt0);
  assign v1_next = enq1 | (v1 & ~gnt1);

  always_comb begin
    age_next = age;
    if (v0_next && v1_next) begin
      if (enq0 && enq1)  age_next = 1'b0;
      else if (enq0)     age_next = 1'b1;
      else if (enq1)     age_next = 1'b0;
    end else if (v1_next) begin
      age_next = 1'b1;
    end else begin
      age_next = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) age <= 1'b0;
    else        age <= age_next;
  end

  // Output stage: one write per cycle; address/data hold when idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WE      <= 1'b0;
      ADDR_IN <= '0;
      D_IN    <= '0;
    end else if (gnt0) begin
      WE      <= 1'b1;
      ADDR_IN <= a0;
      D_IN    <= d0;
    end else if (gnt1) begin
      WE      <= 1'b1;
      ADDR_IN <= a1;
      D_IN    <= d1;
    end else begin
      WE      <= 1'b0;
    end
  end

  // Pending check. Priority younger slot > older slot > output stage, so the
  // reader always sees the value the RegFile will finally hold.
  logic m0, m1, mo;
  assign m0 = v0 & (a0 == CHK_ADDR);
  assign m1 = v1 & (a1 == CHK_ADDR);
  assign mo = WE & (ADDR_IN == CHK_ADDR);
  assign CHK_PENDING = m0 | m1 | mo;

  always_comb begin
    CHK_DATA = '0;
    if (m0 && m1)  CHK_DATA = age ? d0 : d1;
    else if (m1)   CHK_DATA = d1;
    else if (m0)   CHK_DATA = d0;
    else if (mo)   CHK_DATA = D_IN;
  end

endmodule

// File: tb/tb_regfile_write_merge.sv
// Bench for regfile_write_merge: directed cases plus randomized traffic against
// an arrival-ordered queue model of pending writes.
module tb_regfile_write_merge;

  localparam int AW = 5;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic          EN_REQ0, EN_REQ1;
  logic [AW-1:0] REQ0_ADDR, REQ1_ADDR, CHK_ADDR;
  logic [DW-1:0] REQ0_DATA, REQ1_DATA;
  logic          RDY_REQ0, RDY_REQ1, WE, CHK_PENDING;
  logic [AW-1:0] ADDR_IN;
  logic [DW-1:0] D_IN, CHK_DATA;

  regfile_write_merge #(.addr_width(AW), .data_width(DW)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .EN_REQ0     (EN_REQ0),
    .REQ0_ADDR   (REQ0_ADDR),
    .REQ0_DATA   (REQ0_DATA),
    .RDY_REQ0    (RDY_REQ0),
    .EN_REQ1     (EN_REQ1),
    .REQ1_ADDR   (REQ1_ADDR),
    .REQ1_DATA   (REQ1_DATA),
    .RDY_REQ1    (RDY_REQ1),
    .WE          (WE),
    .ADDR_IN     (ADDR_IN),
    .D_IN        (D_IN),
    .CHK_ADDR    (CHK_ADDR),
    .CHK_PENDING (CHK_PENDING),
    .CHK_DATA    (CHK_DATA)
  );

  // RegFile stand-in fed by the write port.
  logic [DW-1:0] regfile_mem [0:(1<<AW)-1];
  always @(posedge CLK) if (WE) regfile_mem[ADDR_IN] <= D_IN;

  // ---------------- scoreboard / model ----------------
  typedef struct {
    logic          ch;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           pend_q[$];   // writes not yet on the port, oldest first
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] exp_q[$];    // data expected on the port, in order

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic busy(input logic ch);
    foreach (pend_q[i]) if (pend_q[i].ch == ch) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    pend_q.delete();
    exp_q.delete();
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic check_chk();
    logic          found;
    logic [DW-1:0] d;
    found = 1'b0;
    d     = '0;
    for (int i = pend_q.size() - 1; i >= 0; i--)
      if (!found && pend_q[i].addr == CHK_ADDR) begin
        found = 1'b1;
        d     = pend_q[i].data;
      end
    if (!found && m_we && m_addr == CHK_ADDR) begin
      found = 1'b1;
      d     = m_data;
    end
    check_eq("chk_pending", CHK_PENDING, found);
    check_eq("chk_data", CHK_DATA, d);
  endtask

  // ---------------- driver ----------------
  // Called just after a posedge; drives inputs, checks the pre-edge view,
  // advances one edge and checks the write port.
  task automatic step(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic [AW-1:0] ca);
    logic acc0, acc1;
    EN_REQ0 = e0; REQ0_ADDR = a0; REQ0_DATA = d0;
    EN_REQ1 = e1; REQ1_ADDR = a1; REQ1_DATA = d1;
    CHK_ADDR = ca;
    #1;
    check_eq("rdy0", RDY_REQ0, !busy(1'b0));
    check_eq("rdy1", RDY_REQ1, !busy(1'b1));
    check_chk();
    acc0 = e0 && !busy(1'b0);
    acc1 = e1 && !busy(1'b1);
    @(posedge CLK);
    if (pend_q.size() > 0) begin
      m_we   = 1'b1;
      m_addr = pend_q[0].addr;
      m_data = pend_q[0].data;
      exp_q.push_back(pend_q[0].data);
      void'(pend_q.pop_front());
    end else begin
      m_we = 1'b0;
    end
    if (acc0) pend_q.push_back('{1'b0, a0, d0});
    if (acc1) pend_q.push_back('{1'b1, a1, d1});
    #1;
    check_eq("we", WE, m_we);
    check_eq("addr_in", ADDR_IN, m_addr);
    check_eq("d_in", D_IN, m_data);
    if (WE && exp_q.size() > 0) check_eq("write_order", D_IN, exp_q.pop_front());
  endtask

  task automatic idle(input logic [AW-1:0] ca);
    step(1'b0, '0, '0, 1'b0, '0, '0, ca);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST_N = 1'b0;
    EN_REQ0 = 1'b1; REQ0_ADDR = 5'd9; REQ0_DATA = 32'hDEAD;
    EN_REQ1 = 1'b0; REQ1_ADDR = '0;  REQ1_DATA = '0;
    CHK_ADDR = '0;
    model_reset();

    // Reset hold with a request asserted.
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_rdy0", RDY_REQ0, 1'b0);
    check_eq("rst_rdy1", RDY_REQ1, 1'b0);
    check_eq("rst_we", WE, 1'b0);
    check_eq("rst_addr", ADDR_IN, '0);
    check_eq("rst_din", D_IN, '0);
    check_eq("rst_pending", CHK_PENDING, 1'b0);
    EN_REQ0 = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check_eq("rel_rdy0", RDY_REQ0, 1'b1);
    check_eq("rel_rdy1", RDY_REQ1, 1'b1);
    @(posedge CLK);
    #1;
    check_eq("rel_we", WE, 1'b0);

    // Single write.
    step(1'b1, 5'd3, 32'hA5, 1'b0, '0, '0, 5'd3);
    check_eq("t2_rdy0_busy", RDY_REQ0, 1'b0);
    idle(5'd3);
    check_eq("t2_we", WE, 1'b1);
    check_eq("t2_addr", ADDR_IN, 5'd3);
    check_eq("t2_din", D_IN, 32'hA5);
    idle(5'd3);
    check_eq("t2_we_off", WE, 1'b0);

    // Same-edge collision plus forwarding.
    step(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 5'd7);
    check_eq("t5_pend_e0", CHK_PENDING, 1'b1);
    check_eq("t5_data_e0", CHK_DATA, 32'h22);
    idle(5'd7);
    check_eq("t3_first", D_IN, 32'h11);
    check_eq("t5_data_e1", CHK_DATA, 32'h22);
    idle(5'd7);
    check_eq("t3_second", D_IN, 32'h22);
    check_eq("t5_data_e2", CHK_DATA, 32'h22);
    idle(5'd7);
    check_eq("t5_pend_e3", CHK_PENDING, 1'b0);
    check_eq("t5_data_e3", CHK_DATA, '0);
    check_eq("t3_regfile7", regfile_mem[7], 32'h22);

    // Age order across edges.
    step(1'b0, '0, '0, 1'b1, 5'd2, 32'hB, 5'd2);
    step(1'b1, 5'd2, 32'hC, 1'b0, '0, '0, 5'd2);
    check_eq("t4_first", D_IN, 32'hB);
    idle(5'd2);
    check_eq("t4_second", D_IN, 32'hC);
    idle(5'd2);
    check_eq("t4_regfile2", regfile_mem[2], 32'hC);

    // Mid-operation reset with both slots full and a write on the port.
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h55, 5'd4);
    step(1'b1, 5'd6, 32'h66, 1'b0, '0, '0, 5'd5);
    check_eq("t6_we_before", WE, 1'b1);
    #1 RST_N = 1'b0;
    #1;
    check_eq("t6_we_drop", WE, 1'b0);
    check_eq("t6_rdy0_low", RDY_REQ0, 1'b0);
    check_eq("t6_rdy1_low", RDY_REQ1, 1'b0);
    model_reset();
    EN_REQ0 = 1'b0;
    #1 RST_N = 1'b1;
    #1;
    check_eq("t6_rdy0_rel", RDY_REQ0, 1'b1);
    check_eq("t6_rdy1_rel", RDY_REQ1, 1'b1);
    idle(5'd4);
    idle(5'd5);
    check_eq("t6_no_replay", WE, 1'b0);

    // Randomized traffic on a small address range to force collisions.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
           AW'($urandom_range(0, 7)));
    end
    repeat (4) idle(AW'($urandom_range(0, 7)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
